// File: rtl/riscboy_ppu_pixel_unpacker_if.sv
// Packed-word input stream and unpacked-pixel output stream of the PPU pixel unpacker.
// The slave modport is the unpacker. The master modport is the fetch path plus the palette mapper.
interface riscboy_ppu_pixel_unpacker_if #(
   parameter int W_DATA    = 32,
   parameter int W_PIXDATA = 15
);
   logic                 in_vld;
   logic                 in_rdy;
   logic [W_DATA-1:0]    in_data;
   logic                 out_vld;
   logic                 out_rdy;
   logic [W_PIXDATA-1:0] out_data;
   logic                 out_paletted;

   modport master (
      output in_vld, in_data, out_rdy,
      input  in_rdy, out_vld, out_data, out_paletted
   );

   modport slave (
      input  in_vld, in_data, out_rdy,
      output in_rdy, out_vld, out_data, out_paletted
   );
endinterface

// File: rtl/riscboy_ppu_pixel_unpacker.sv
// Unpacks 32-bit pixel words into one pixel per handshake for the PPU palette mapper.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no span; waits for start (a count of zero only pulses done)
// S_ACTIVE | span running; pixels remain to be emitted
module riscboy_ppu_pixel_unpacker #(
   parameter int W_DATA        = 32,
   parameter int W_PIXDATA     = 15,
   parameter int W_PALETTE_IDX = 8,
   parameter int W_COUNT       = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [1:0]         start_pixmode,
   input  logic [W_COUNT-1:0] start_count,
   input  logic [4:0]         start_skip,
   input  logic               flush,
   riscboy_ppu_pixel_unpacker_if.slave bus,
   output logic               busy,
   output logic               done
);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   localparam logic [1:0] MODE_16BPP = 2'd0;
   localparam logic [1:0] MODE_8BPP  = 2'd1;
   localparam logic [1:0] MODE_4BPP  = 2'd2;

   // Index of the last pixel in a word (pixels-per-word minus one)
   function automatic logic [4:0] f_ptr_max(input logic [1:0] mode);
      case (mode)
         MODE_16BPP: f_ptr_max = 5'd1;
         MODE_8BPP:  f_ptr_max = 5'd3;
         MODE_4BPP:  f_ptr_max = 5'd7;
         default:    f_ptr_max = 5'd31;
      endcase
   endfunction

   state_t               r_state;
   state_t               w_state_nxt;
   logic [1:0]           r_mode;
   logic [W_COUNT-1:0]   r_remaining;
   logic [W_DATA-1:0]    r_buf;
   logic                 r_buf_vld;
   logic [4:0]           r_ptr;
   logic [4:0]           r_skip;
   logic                 r_first;
   logic                 r_done;

   logic [4:0]           w_ptr_max;
   logic                 w_last_of_word;
   logic [5:0]           w_buf_left;
   logic                 w_words_needed;
   logic                 w_last_pix;
   logic                 w_out_vld;
   logic                 w_in_rdy;
   logic                 w_xfer;
   logic                 w_in_hs;
   logic [W_PIXDATA-1:0] w_pix;
   logic                 w_paletted;
   logic                 w_busy;

   assign w_ptr_max      = f_ptr_max(r_mode);
   assign w_last_of_word = (r_ptr == w_ptr_max);
   assign w_buf_left     = {1'b0, w_ptr_max} + 6'd1 - {1'b0, r_ptr};
   assign w_last_pix     = (r_remaining == W_COUNT'(1));
   // More pixels are owed than the buffered word still holds
   assign w_words_needed = r_buf_vld ? (r_remaining > W_COUNT'(w_buf_left))
                                     : (r_remaining != '0);
   assign w_xfer         = w_out_vld && bus.out_rdy;
   assign w_in_hs        = bus.in_vld && w_in_rdy;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start && !flush && (start_count != '0)) begin
               w_state_nxt = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (flush) begin
               w_state_nxt = S_IDLE;
            end else if (w_xfer && w_last_pix) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy     = (r_state == S_ACTIVE);
      w_out_vld  = w_busy && r_buf_vld;
      // Refill in the same cycle the last pixel of a word leaves, for zero-bubble throughput
      w_in_rdy   = w_busy && w_words_needed &&
                   (!r_buf_vld || (bus.out_rdy && w_last_of_word && !w_last_pix));
      w_pix      = '0;
      w_paletted = 1'b0;
      if (w_out_vld) begin
         case (r_mode)
            MODE_16BPP: begin
               w_pix = r_buf[{r_ptr[0], 4'b0000} +: W_PIXDATA];
            end
            MODE_8BPP: begin
               w_pix      = W_PIXDATA'(r_buf[{r_ptr[1:0], 3'b000} +: W_PALETTE_IDX]);
               w_paletted = 1'b1;
            end
            MODE_4BPP: begin
               w_pix      = W_PIXDATA'(r_buf[{r_ptr[2:0], 2'b00} +: 4]);
               w_paletted = 1'b1;
            end
            default: begin
               w_pix      = W_PIXDATA'(r_buf[r_ptr]);
               w_paletted = 1'b1;
            end
         endcase
      end
   end

   assign bus.in_rdy       = w_in_rdy;
   assign bus.out_vld      = w_out_vld;
   assign bus.out_data     = w_pix;
   assign bus.out_paletted = w_paletted;
   assign busy             = w_busy;
   assign done             = r_done;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mode      <= MODE_16BPP;
         r_remaining <= '0;
         r_buf       <= '0;
         r_buf_vld   <= 1'b0;
         r_ptr       <= '0;
         r_skip      <= '0;
         r_first     <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (flush) begin
            r_buf_vld   <= 1'b0;
            r_remaining <= '0;
            r_ptr       <= '0;
            r_first     <= 1'b0;
         end else if (r_state == S_IDLE) begin
            if (start) begin
               r_mode      <= start_pixmode;
               r_remaining <= start_count;
               r_skip      <= start_skip & f_ptr_max(start_pixmode);
               r_ptr       <= '0;
               r_first     <= 1'b1;
               r_done      <= (start_count == '0);
            end
         end else begin
            if (w_xfer) begin
               r_remaining <= r_remaining - W_COUNT'(1);
               r_ptr       <= r_ptr + 5'd1;
               if (w_last_of_word || w_last_pix) begin
                  r_buf_vld <= 1'b0;
               end
               if (w_last_pix) begin
                  r_done <= 1'b1;
               end
            end
            // A new word overrides the emptying above; only the first word honours skip
            if (w_in_hs) begin
               r_buf     <= bus.in_data;
               r_buf_vld <= 1'b1;
               r_ptr     <= r_first ? r_skip : 5'd0;
               r_first   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_riscboy_ppu_pixel_unpacker.sv
// Directed bench for the pixel unpacker: span vector table plus flush, zero-count and reset sequences.
module tb_riscboy_ppu_pixel_unpacker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [1:0] start_pixmode;
   logic [9:0] start_count;
   logic [4:0] start_skip;
   logic       flush;
   logic       busy;
   logic       done;

   int total = 0;
   int bad   = 0;

   riscboy_ppu_pixel_unpacker_if #(.W_DATA(32), .W_PIXDATA(15)) bus ();

   riscboy_ppu_pixel_unpacker dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .start_pixmode(start_pixmode),
      .start_count  (start_count),
      .start_skip   (start_skip),
      .flush        (flush),
      .bus          (bus),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      string           name;
      logic [1:0]      mode;
      logic [9:0]      count;
      logic [4:0]      skip;
      logic [31:0]     w0;
      logic [31:0]     w1;
      int              nwords;
      logic [7:0][14:0] exp;
      logic            pal;
      int              stall_at;
      int              stall_len;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0][14:0] px8(input int a0, a1, a2, a3, a4, a5, a6, a7);
      logic [7:0][14:0] r;
      r[0] = 15'(a0); r[1] = 15'(a1); r[2] = 15'(a2); r[3] = 15'(a3);
      r[4] = 15'(a4); r[5] = 15'(a5); r[6] = 15'(a6); r[7] = 15'(a7);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_span(input string name, input logic [1:0] mode, input logic [9:0] count,
                           input logic [4:0] skip, input logic [31:0] w0, input logic [31:0] w1,
                           input int nwords, input logic [63:0][14:0] exp, input logic pal,
                           input int stall_at, input int stall_len);
      int pix = 0;
      int hs = 0;
      int cyc = 0;
      int first_x = -1;
      int last_x = -1;
      int done_cyc = -1;
      int stall_cnt = 0;
      logic [1:0][31:0] words;
      words[0] = w0;
      words[1] = w1;
      start = 1'b1;
      start_pixmode = mode;
      start_count = count;
      start_skip = skip;
      bus.in_vld = 1'b0;
      bus.out_rdy = 1'b1;
      tick();
      // Scramble the start inputs; the span must keep its latched settings
      start = 1'b0;
      start_pixmode = ~mode;
      start_count = 10'h3FF;
      start_skip = 5'h1F;
      while (done_cyc < 0 && cyc < 300) begin
         bus.in_vld = 1'b1;
         bus.in_data = (hs < nwords) ? words[hs[0]] : 32'hDEAD_BEEF;
         bus.out_rdy = !(stall_len > 0 && pix == stall_at && stall_cnt < stall_len);
         @(negedge clk);
         if (done) done_cyc = cyc;
         if (!bus.out_rdy) begin
            stall_cnt++;
            chk($sformatf("%s stall out_vld", name), 32'(bus.out_vld), 32'd1);
            chk($sformatf("%s stall out_data", name), 32'(bus.out_data), 32'(exp[pix]));
            chk($sformatf("%s stall in_rdy", name), 32'(bus.in_rdy), 32'd0);
         end
         if (bus.out_vld && bus.out_rdy && pix < 64) begin
            chk($sformatf("%s pix%0d data", name, pix), 32'(bus.out_data), 32'(exp[pix]));
            chk($sformatf("%s pix%0d paletted", name, pix), 32'(bus.out_paletted), 32'(pal));
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
            pix++;
         end
         if (bus.in_rdy) hs++;
         tick();
         cyc++;
      end
      chk($sformatf("%s done seen", name), 32'(done_cyc >= 0), 32'd1);
      chk($sformatf("%s pixel count", name), 32'(pix), 32'(count));
      chk($sformatf("%s words accepted", name), 32'(hs), 32'(nwords));
      chk($sformatf("%s done timing", name), 32'(done_cyc), 32'(last_x + 1));
      chk($sformatf("%s no bubble", name), 32'(last_x - first_x), 32'(int'(count) - 1 + stall_len));
      @(negedge clk);
      chk($sformatf("%s done width", name), 32'(done), 32'd0);
      chk($sformatf("%s busy after", name), 32'(busy), 32'd0);
      chk($sformatf("%s in_rdy after", name), 32'(bus.in_rdy), 32'd0);
      bus.in_vld = 1'b0;
      tick();
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, " in_rdy"}, 32'(bus.in_rdy), 32'd0);
      chk({name, " out_vld"}, 32'(bus.out_vld), 32'd0);
      chk({name, " out_data"}, 32'(bus.out_data), 32'd0);
      chk({name, " out_paletted"}, 32'(bus.out_paletted), 32'd0);
      chk({name, " busy"}, 32'(busy), 32'd0);
      chk({name, " done"}, 32'(done), 32'd0);
   endtask

   initial begin
      logic [63:0][14:0] e64;

      vecs[0] = '{"4bpp_basic",  2'd2, 10'd8,  5'd0,  32'h7654_3210, 32'h0, 1,
                  px8(0, 1, 2, 3, 4, 5, 6, 7), 1'b1, 0, 0};
      vecs[1] = '{"16bpp",       2'd0, 10'd2,  5'd0,  32'hABCD_1234, 32'h0, 1,
                  px8('h1234, 'h2BCD, 0, 0, 0, 0, 0, 0), 1'b0, 0, 0};
      vecs[2] = '{"8bpp_skip2",  2'd1, 10'd3,  5'd2,  32'h4433_2211, 32'h8877_6655, 2,
                  px8('h33, 'h44, 'h55, 0, 0, 0, 0, 0), 1'b1, 0, 0};
      vecs[3] = '{"16bpp_skip3", 2'd0, 10'd2,  5'd3,  32'h1111_2222, 32'h0000_3333, 2,
                  px8('h1111, 'h3333, 0, 0, 0, 0, 0, 0), 1'b0, 0, 0};
      vecs[4] = '{"4bpp_skip6",  2'd2, 10'd3,  5'd6,  32'hFEDC_BA98, 32'h0000_0005, 2,
                  px8('hE, 'hF, 'h5, 0, 0, 0, 0, 0), 1'b1, 0, 0};
      vecs[5] = '{"1bpp_skip30", 2'd3, 10'd5,  5'd30, 32'h8000_0000, 32'h0000_0005, 2,
                  px8(0, 1, 1, 0, 1, 0, 0, 0), 1'b1, 0, 0};
      vecs[6] = '{"8bpp_short",  2'd1, 10'd2,  5'd0,  32'hFFFF_80FF, 32'h0, 1,
                  px8('hFF, 'h80, 0, 0, 0, 0, 0, 0), 1'b1, 0, 0};
      vecs[7] = '{"8bpp_stall",  2'd1, 10'd6,  5'd0,  32'h0403_0201, 32'h0000_0605, 2,
                  px8(1, 2, 3, 4, 5, 6, 0, 0), 1'b1, 3, 5};
      vecs[8] = '{"4bpp_stall",  2'd2, 10'd8,  5'd0,  32'h7654_3210, 32'h0, 1,
                  px8(0, 1, 2, 3, 4, 5, 6, 7), 1'b1, 2, 5};

      rst_n = 1'b0;
      start = 1'b0;
      start_pixmode = 2'd0;
      start_count = '0;
      start_skip = '0;
      flush = 1'b0;
      bus.in_vld = 1'b0;
      bus.in_data = '0;
      bus.out_rdy = 1'b1;
      tick();
      tick();
      @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 9; i++) begin
         e64 = '0;
         for (int k = 0; k < 8; k++) e64[k] = vecs[i].exp[k];
         run_span(vecs[i].name, vecs[i].mode, vecs[i].count, vecs[i].skip, vecs[i].w0, vecs[i].w1,
                  vecs[i].nwords, e64, vecs[i].pal, vecs[i].stall_at, vecs[i].stall_len);
      end

      // 1bpp, two full words back to back
      e64 = '0;
      for (int k = 0; k < 32; k++) begin
         e64[k]      = 15'(((32'hA5A5_A5A5) >> k) & 32'd1);
         e64[k + 32] = 15'(((32'h0F0F_0F0F) >> k) & 32'd1);
      end
      run_span("1bpp_64", 2'd3, 10'd64, 5'd0, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 2, e64, 1'b1, 0, 0);

      // Flush mid-span
      start = 1'b1; start_pixmode = 2'd2; start_count = 10'd8; start_skip = 5'd0;
      tick();
      start = 1'b0;
      bus.in_vld = 1'b1; bus.in_data = 32'h7654_3210; bus.out_rdy = 1'b1;
      tick();
      bus.in_vld = 1'b0;
      tick();
      tick();
      @(negedge clk);
      chk("flush pre busy", 32'(busy), 32'd1);
      chk("flush pre out_data", 32'(bus.out_data), 32'd2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("flush busy", 32'(busy), 32'd0);
      chk("flush out_vld", 32'(bus.out_vld), 32'd0);
      chk("flush in_rdy", 32'(bus.in_rdy), 32'd0);
      for (int k = 0; k < 3; k++) begin
         chk("flush no done", 32'(done), 32'd0);
         tick();
         @(negedge clk);
      end

      // Flush beats a simultaneous start
      tick();
      start = 1'b1; flush = 1'b1; start_count = 10'd4;
      tick();
      start = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("flush+start busy", 32'(busy), 32'd0);
      chk("flush+start done", 32'(done), 32'd0);
      tick();

      // Zero-count span
      start = 1'b1; start_pixmode = 2'd1; start_count = 10'd0;
      bus.in_vld = 1'b1; bus.in_data = 32'h1234_5678;
      @(negedge clk);
      chk("count0 in_rdy start", 32'(bus.in_rdy), 32'd0);
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("count0 done", 32'(done), 32'd1);
      chk("count0 busy", 32'(busy), 32'd0);
      chk("count0 in_rdy", 32'(bus.in_rdy), 32'd0);
      tick();
      @(negedge clk);
      chk("count0 done width", 32'(done), 32'd0);
      bus.in_vld = 1'b0;
      tick();

      // Reset mid-span
      start = 1'b1; start_pixmode = 2'd0; start_count = 10'd4; start_skip = 5'd0;
      tick();
      start = 1'b0;
      bus.in_vld = 1'b1; bus.in_data = 32'hABCD_1234;
      tick();
      bus.in_vld = 1'b0;
      @(negedge clk);
      chk("rst pre out_vld", 32'(bus.out_vld), 32'd1);
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      check_reset_outputs("midspan rst");
      rst_n = 1'b1;
      tick();

      e64 = '0;
      e64[0] = 15'h1234;
      e64[1] = 15'h2BCD;
      run_span("after_rst", 2'd0, 10'd2, 5'd0, 32'hABCD_1234, 32'h0, 1, e64, 1'b0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/riscboy_ppu_pixel_unpacker.md
Name: riscboy_ppu_pixel_unpacker

Overview:
Sits directly upstream of the PPU palette mapper. It accepts 32-bit packed pixel words from the PPU fetch path, unpacks them into one pixel per handshake in the configured format, and presents each pixel with a paletted flag. A per-span command (start, count, skip) bounds each run of pixels. Output is a valid/ready stream that drives the mapper's pixel input directly.

Parameters:
W_DATA, 32, packed input word width; fixed at 32.
W_PIXDATA, 15, output pixel width (direct colour RGB555).
W_PALETTE_IDX, 8, palette index width; paletted output is zero-extended to W_PIXDATA.
W_COUNT, 10, width of span pixel count.

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
start  input  1  span start pulse
start_pixmode  input  2  0=16bpp direct, 1=8bpp, 2=4bpp, 3=1bpp paletted
start_count  input  W_COUNT  number of pixels to emit for the span
start_skip  input  5  leading pixels to discard from the first word
flush  input  1  abort the current span
in_vld  input  1  packed word valid
in_rdy  output  1  packed word accepted
in_data  input  W_DATA  packed word
out_vld  output  1  pixel valid
out_rdy  input  1  downstream ready
out_data  output  W_PIXDATA  pixel colour or zero-extended index
out_paletted  output  1  1 = out_data is a palette index
busy  output  1  span in progress
done  output  1  one-cycle pulse after the last pixel of a span transfers

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n).
- Reset values: state IDLE, word buffer invalid, counters 0, in_rdy=0, out_vld=0, out_data=0, out_paletted=0, busy=0, done=0.
- Pixels-per-word (PPW) by mode: 2, 4, 8, 32. Pixel k of a word is at bits [k*bpp +: bpp], with pixel 0 at the LSBs.
- 16bpp: out_data = pixel[14:0]; bit 15 is dropped; out_paletted=0. Other modes: out_data = index zero-extended; out_paletted=1.
- States:
  - IDLE.
  - ACTIVE: running the span; remaining > 0.
  - On IDLE with start: latch mode, count and skip. Effective skip is start_skip mod PPW, so only the low log2(PPW) bits are used.
  - start_count = 0: stay IDLE and pulse done the next cycle; no word is consumed.
  - start while ACTIVE is ignored.
- Word buffer: one 32-bit register plus a pixel pointer. out_vld = ACTIVE && buffer valid. out_data and out_paletted come from registers only; no combinational path from in_data.
- First word: pointer loads the effective skip. Later words: pointer loads 0.
- On each out_vld && out_rdy: remaining decrements and the pointer increments. The buffer empties when the pointer reaches PPW-1 or remaining reaches 1.
- in_rdy = ACTIVE && words_needed && (!buf_vld || (out_rdy && current pixel is the last of its word && remaining > 1)).
  - words_needed means pixels remain beyond the buffered word.
  - This gives zero-bubble throughput: 1 pixel per cycle with continuous in_vld and out_rdy.
- Latency: word accepted in cycle N; its first pixel is valid in cycle N+1.
- Output stability: out_vld, out_data and out_paletted are held unchanged while out_rdy is low.
- Span end: the last pixel transfers in cycle M. Then done=1 in M+1, state returns to IDLE, and unused pixels in the final word are discarded. No extra word is requested.
- busy = state is ACTIVE.
- flush: next cycle goes to IDLE, invalidates the buffer and clears remaining. No done pulse. flush beats start in the same cycle; that start is ignored.
- Reset mid-span: all state returns to reset values on the next edge; a partially consumed word is lost.
- Mode and count are frozen for the whole span; changes on start_* inputs after the start cycle have no effect.

Test Plan:
- 4bpp, count=8, skip=0, word 0x76543210, out_rdy=1 -> out_data 0,1,...,7 on 8 consecutive cycles; out_paletted=1; one in handshake; done pulses the cycle after pixel 7.
- 16bpp, count=2, word 0xABCD1234 -> out_data 0x1234 then 0x2BCD; out_paletted=0.
- 8bpp, count=3, skip=2, words 0x44332211 and 0x88776655 -> pixels 0x33, 0x44, 0x55; exactly 2 words accepted; no third in_rdy; done pulses.
- 1bpp, count=64, two words, in_vld and out_rdy held high -> 64 consecutive out_vld cycles with no bubble at the word boundary.
- Backpressure: out_rdy low for 5 cycles mid-word -> out_vld and out_data held stable, in_rdy=0, remaining unchanged. flush mid-span -> IDLE next cycle, no done.
- start with count=0 -> no in_rdy, done next cycle. rst_n low mid-span -> all outputs at reset values on the next edge.
